read_pointer_empty: RTL and testbench
=====================================

Name: read_pointer_empty

Overview:
Read-side pointer and status stage of the asynchronous FIFO. It sits directly downstream of the write-to-read pointer synchronizer and consumes the synchronized Gray write pointer. It keeps the read pointer in binary and Gray form, supplies the RAM read address, and returns the Gray read pointer for synchronization into the write domain. It produces registered empty, almost-empty and occupancy status, all in the read_clk domain.

Parameters:
address_size, 4, RAM address width; FIFO depth = 2**address_size; pointers are address_size+1 bits.
almost_empty_level, 2, read_almost_empty asserts when the occupancy is at or below this value.

Ports:
read_clk  input  1  read-domain clock; all state updates on its rising edge.
rreset_n  input  1  asynchronous active-low reset.
read_inc  input  1  read request; honoured only when read_empty=0.
write_pointer_s  input  address_size+1  Gray write pointer, already synchronized into read_clk.
read_address  output  address_size  RAM read address = low bits of the binary read pointer.
read_pointer  output  address_size+1  registered Gray read pointer, sent to the read-to-write synchronizer.
read_empty  output  1  registered empty flag.
read_almost_empty  output  1  registered; 1 when occupancy <= almost_empty_level.
read_count  output  address_size+1  registered occupancy, range 0..2**address_size.

Behaviour:
- Registers: rbin (binary read pointer), read_pointer (Gray), read_empty, read_almost_empty, read_count.
- Reset (asynchronous, rreset_n=0): rbin=0, read_pointer=0, read_empty=1, read_almost_empty=1, read_count=0. Reset asserted mid-burst discards all state immediately. After deassertion, operation resumes on the next read_clk edge.
- rinc_eff = read_inc & ~read_empty. A read while empty is ignored and the pointers hold.
- rbin_next = rbin + rinc_eff, modulo 2**(address_size+1). The extra MSB distinguishes wrap laps.
- rgray_next = (rbin_next >> 1) ^ rbin_next. read_pointer <= rgray_next, so exactly one bit changes per increment.
- read_address = rbin[address_size-1:0]. It is combinational from the register and presents the address of the current head entry.
- read_empty <= (rgray_next == write_pointer_s).
- wbin_s = Gray-to-binary of write_pointer_s: bit i = XOR of bits address_size..i.
- count_next = (wbin_s - rbin_next) modulo 2**(address_size+1). read_count <= count_next.
- read_almost_empty <= (count_next <= almost_empty_level).
- Latency: a change on write_pointer_s is reflected in read_empty, read_count and read_almost_empty after one read_clk edge. A read updates all outputs at the same edge it is accepted.
- Status is pessimistic by design. The synchronized write pointer lags, so empty may assert early or deassert late, but is never falsely deasserted.
- Simultaneous read and write_pointer_s change: both are applied in the same next-state computation. No priority is needed.
- Wrap-around: rbin rolls from 2**(address_size+1)-1 to 0 and read_address wraps from 2**address_size-1 to 0 without glitch or stall.
- A full FIFO, seen from the read side, gives read_count = 2**address_size (MSB set, low bits 0) with read_empty=0.

Optional Feature:
READ_UNDERFLOW_FLAG_EN
- Defined: adds two ports, underflow_clear (input, 1) and read_underflow (output, 1, reset 0).
  - read_underflow becomes a sticky 1 on the edge after read_inc=1 while read_empty=1.
  - underflow_clear=1 clears it on the next edge. If both happen on the same edge, set wins.
  - Pointers are unaffected in every case.
- Undefined: neither port exists and reads while empty are silently ignored.

Test Plan:
- Reset: hold rreset_n=0 and toggle read_inc -> read_empty=1, read_almost_empty=1, read_count=0, read_pointer=5'b00000, read_address=0.
- Occupancy: write_pointer_s=5'b00010 (gray 3), read_inc=0 -> one edge later read_empty=0, read_count=3, read_almost_empty=0. Then assert read_inc for 3 edges:
  - read_address presents 0, 1, 2 at those edges;
  - read_count steps 2, 1, 0;
  - read_almost_empty=1 from the first read; read_empty=1 after the third read.
- Read while empty: read_inc=1 for 4 edges with write_pointer_s equal to read_pointer -> rbin, read_address and read_pointer unchanged. With READ_UNDERFLOW_FLAG_EN, read_underflow=1 and stays 1 until underflow_clear pulses.
- Full and wrap: from reset set write_pointer_s=5'b11000 (gray 16) -> read_count=16, read_empty=0. Read 16 times -> read_address sequence 0..15, then read_pointer=5'b11000 and read_empty=1. Next lap: write_pointer_s=gray 18 -> read_address continues 0, 1.
- Gray property: across 40 consecutive reads, check every read_pointer transition changes exactly one bit and matches gray(rbin).
- Mid-burst reset: pulse rreset_n low asynchronously, between edges, during continuous reads -> outputs return to reset values immediately, without waiting for a read_clk edge.

Source files
------------

// File: rtl/read_pointer_empty.sv
// Read-side pointer, RAM read address and registered empty/occupancy status of an async FIFO.
// Optional sticky underflow flag under READ_UNDERFLOW_FLAG_EN.
module read_pointer_empty #(
    parameter int address_size       = 4,
    parameter int almost_empty_level = 2
) (
    input  logic                    read_clk,
    input  logic                    rreset_n,
    input  logic                    read_inc,
    input  logic [address_size:0]   write_pointer_s,
`ifdef READ_UNDERFLOW_FLAG_EN
    input  logic                    underflow_clear,
    output logic                    read_underflow,
`endif
    output logic [address_size-1:0] read_address,
    output logic [address_size:0]   read_pointer,
    output logic                    read_empty,
    output logic                    read_almost_empty,
    output logic [address_size:0]   read_count
);

    localparam logic [address_size:0] AE_LEVEL = almost_empty_level[address_size:0];

    logic [address_size:0] rbin;
    logic [address_size:0] rbin_next;
    logic [address_size:0] rgray_next;
    logic [address_size:0] wbin_s;
    logic [address_size:0] count_next;
    logic                  rinc_eff;

    always_comb begin
        rinc_eff   = read_inc & ~read_empty;
        rbin_next  = rbin + {{address_size{1'b0}}, rinc_eff};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        // Gray to binary: each bit is the XOR of itself and all higher Gray bits
        wbin_s               = '0;
        wbin_s[address_size] = write_pointer_s[address_size];
        for (int i = address_size - 1; i >= 0; i--) begin
            wbin_s[i] = wbin_s[i+1] ^ write_pointer_s[i];
        end
        count_next = wbin_s - rbin_next;
    end

    always_ff @(posedge read_clk or negedge rreset_n) begin
        if (!rreset_n) begin
            rbin              <= '0;
            read_pointer      <= '0;
            read_empty        <= 1'b1;
            read_almost_empty <= 1'b1;
            read_count        <= '0;
        end else begin
            rbin              <= rbin_next;
            read_pointer      <= rgray_next;
            read_empty        <= (rgray_next == write_pointer_s);
            read_almost_empty <= (count_next <= AE_LEVEL);
            read_count        <= count_next;
        end
    end

    assign read_address = rbin[address_size-1:0];

`ifdef READ_UNDERFLOW_FLAG_EN
    // Set has priority over clear so a same-edge underflow is never lost
    always_ff @(posedge read_clk or negedge rreset_n) begin
        if (!rreset_n) begin
            read_underflow <= 1'b0;
        end else if (read_inc & read_empty) begin
            read_underflow <= 1'b1;
        end else if (underflow_clear) begin
            read_underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_read_pointer_empty.sv
// Directed bench for read_pointer_empty with an arithmetic occupancy model.
module tb_read_pointer_empty;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
    localparam int AEL   = 2;

    logic          read_clk;
    logic          rreset_n;
    logic          read_inc;
    logic [AW:0]   write_pointer_s;
    logic [AW-1:0] read_address;
    logic [AW:0]   read_pointer;
    logic          read_empty;
    logic          read_almost_empty;
    logic [AW:0]   read_count;
`ifdef READ_UNDERFLOW_FLAG_EN
    logic          underflow_clear;
    logic          read_underflow;
`endif

    read_pointer_empty #(.address_size(AW), .almost_empty_level(AEL)) dut (
        .read_clk          (read_clk),
        .rreset_n          (rreset_n),
        .read_inc          (read_inc),
        .write_pointer_s   (write_pointer_s),
`ifdef READ_UNDERFLOW_FLAG_EN
        .underflow_clear   (underflow_clear),
        .read_underflow    (read_underflow),
`endif
        .read_address      (read_address),
        .read_pointer      (read_pointer),
        .read_empty        (read_empty),
        .read_almost_empty (read_almost_empty),
        .read_count        (read_count)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    initial read_clk = 0;
    always #5 read_clk = ~read_clk;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse Gray by search over the pointer space
    function automatic int ungray(input int g);
        for (int b = 0; b < PMOD; b++) if (gray(b) == g) return b;
        return -1;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: reads accepted and the write position define everything
    int m_rd, m_cnt;
    bit m_empty, m_ae, m_uf;
    always @(posedge read_clk or negedge rreset_n) begin
        if (!rreset_n) begin
            m_rd = 0; m_cnt = 0; m_empty = 1; m_ae = 1; m_uf = 0;
        end else begin
            bit eff;
            eff = read_inc && !m_empty;
`ifdef READ_UNDERFLOW_FLAG_EN
            if (read_inc && m_empty) m_uf = 1;
            else if (underflow_clear) m_uf = 0;
`endif
            m_rd    = (m_rd + int'(eff)) % PMOD;
            m_cnt   = (ungray(int'(write_pointer_s)) - m_rd + PMOD) % PMOD;
            m_empty = (m_cnt == 0);
            m_ae    = (m_cnt <= AEL);
        end
    end

    always @(negedge read_clk) begin
        if (chk_en) begin
            cmp("m_address", int'(read_address), m_rd % DEPTH);
            cmp("m_pointer", int'(read_pointer), gray(m_rd));
            cmp("m_empty", int'(read_empty), int'(m_empty));
            cmp("m_almost_empty", int'(read_almost_empty), int'(m_ae));
            cmp("m_count", int'(read_count), m_cnt);
`ifdef READ_UNDERFLOW_FLAG_EN
            cmp("m_underflow", int'(read_underflow), int'(m_uf));
`endif
        end
    end

    task automatic cyc(input bit inc);
        read_inc = inc;
        @(posedge read_clk);
        @(negedge read_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        cmp({tag, "_empty"}, int'(read_empty), 1);
        cmp({tag, "_ae"}, int'(read_almost_empty), 1);
        cmp({tag, "_count"}, int'(read_count), 0);
        cmp({tag, "_pointer"}, int'(read_pointer), 0);
        cmp({tag, "_address"}, int'(read_address), 0);
    endtask

    initial begin
        int w, rb;
        logic [AW:0] prev;
        rreset_n = 0;
        read_inc = 0;
        write_pointer_s = '0;
`ifdef READ_UNDERFLOW_FLAG_EN
        underflow_clear = 0;
`endif
        @(negedge read_clk);
        chk_en = 1;
        // Reset held while read_inc toggles
        for (int i = 0; i < 4; i++) begin
            cyc(i[0]);
            chk_reset_vals("rst_hold");
        end
        read_inc = 0;
        rreset_n = 1;

        // Occupancy of 3 then drain
        write_pointer_s = 5'b00010;
        cyc(0);
        cmp("occ_empty", int'(read_empty), 0);
        cmp("occ_count", int'(read_count), 3);
        cmp("occ_ae", int'(read_almost_empty), 0);
        for (int i = 0; i < 3; i++) begin
            cmp("drain_addr", int'(read_address), i);
            cyc(1);
            cmp("drain_count", int'(read_count), 2 - i);
            cmp("drain_ae", int'(read_almost_empty), 1);
            cmp("drain_empty", int'(read_empty), (i == 2) ? 1 : 0);
        end

        // Reads while empty are ignored
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            cmp("uread_addr", int'(read_address), 3);
            cmp("uread_ptr", int'(read_pointer), 5'b00010);
`ifdef READ_UNDERFLOW_FLAG_EN
            cmp("uflow_set", int'(read_underflow), 1);
`endif
        end
        read_inc = 0;
`ifdef READ_UNDERFLOW_FLAG_EN
        cyc(0);
        cmp("uflow_hold", int'(read_underflow), 1);
        underflow_clear = 1;
        cyc(0);
        underflow_clear = 0;
        cmp("uflow_clr", int'(read_underflow), 0);
`endif

        // Full FIFO then wrap into next lap
        rreset_n = 0;
        #1;
        chk_reset_vals("rst_pulse");
        @(negedge read_clk);
        rreset_n = 1;
        write_pointer_s = 5'b11000;
        cyc(0);
        cmp("full_count", int'(read_count), 16);
        cmp("full_empty", int'(read_empty), 0);
        for (int i = 0; i < DEPTH; i++) begin
            cmp("full_addr", int'(read_address), i);
            cyc(1);
        end
        cmp("lap_ptr", int'(read_pointer), 5'b11000);
        cmp("lap_empty", int'(read_empty), 1);
        write_pointer_s = 5'(gray(18));
        cyc(0);
        cmp("lap_count", int'(read_count), 2);
        for (int i = 0; i < 2; i++) begin
            cmp("lap_addr", int'(read_address), i);
            cyc(1);
        end
        cmp("lap_empty2", int'(read_empty), 1);

        // Streaming reads with the writer kept 4 ahead
        w  = 22;
        rb = 18;
        write_pointer_s = 5'(gray(w % PMOD));
        cyc(0);
        cmp("stream_count", int'(read_count), 4);
        for (int i = 0; i < 40; i++) begin
            prev = read_pointer;
            w++;
            write_pointer_s = 5'(gray(w % PMOD));
            cyc(1);
            rb = (rb + 1) % PMOD;
            cmp("gray_onebit", $countones(prev ^ read_pointer), 1);
            cmp("gray_value", int'(read_pointer), gray(rb));
        end

        // Asynchronous reset between edges during reads
        @(posedge read_clk);
        #2 rreset_n = 0;
        #1;
        chk_reset_vals("async_rst");
        #1 rreset_n = 1;
        @(negedge read_clk);
        #1;
        for (int i = 0; i < 4; i++) cyc(1);
        read_inc = 0;
        cyc(0);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
